// File: rtl/register_file_pkg.sv
// register_file_pkg: clear-engine state type and address-width helper for register_file_mp
package register_file_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
  function automatic int addr_width(int depth);
    return depth <= 2 ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port; forwards same-edge write data when REGFILE_BYPASS_EN is defined
module regfile_read_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6,
  parameter int AW    = 3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] regs [DEPTH],
`ifdef REGFILE_BYPASS_EN
  input  logic             wr_ok,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
`endif
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);
  logic [WIDTH-1:0] rd_val;
`ifdef REGFILE_BYPASS_EN
  assign rd_val = int'(raddr) >= DEPTH ? '0 : (wr_ok && waddr == raddr) ? wdata : regs[raddr];
`else
  assign rd_val = int'(raddr) >= DEPTH ? '0 : regs[raddr];
`endif
  // capture read data on enable; data holds while the port is idle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= rd_val;
    end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port register file with dirty flags and clear engine; REGFILE_BYPASS_EN enables write-to-read forwarding
module register_file_mp
  import register_file_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 6,
  parameter  int NREAD    = 2,
  parameter  int TAP0     = 1,
  parameter  int TAP1     = 2,
  parameter  int ZERO_REG = 0,
  localparam int AW       = addr_width(DEPTH)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD-1:0]       re,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rvalid,
  input  logic                   clr_req,
  output logic                   busy,
  output logic                   clr_done,
  output logic                   wr_err,
  output logic [DEPTH-1:0]       dirty,
  output logic [WIDTH-1:0]       tap0,
  output logic [WIDTH-1:0]       tap1
);
  logic [WIDTH-1:0] regs [DEPTH];
  clr_state_t       state, state_nx;
  logic [AW-1:0]    cnt;
  logic             wr_ok;
  assign busy     = state == CLEAR;
  assign clr_done = state == DONE;
  assign wr_ok    = we && !busy && int'(waddr) < DEPTH && !(ZERO_REG != 0 && waddr == '0);
  assign tap0     = regs[TAP0];
  assign tap1     = regs[TAP1];
  // clear engine state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // clear engine sequencing: one row per cycle, then a single DONE cycle
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE  ? (clr_req ? CLEAR : IDLE) :
               state == CLEAR ? (int'(cnt) == DEPTH - 1 ? DONE : CLEAR) : IDLE;
  end
  // storage, dirty flags, clear row counter and dropped-write flag; clearing owns the array while busy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
      dirty  <= '0;
      cnt    <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= we && (busy || int'(waddr) >= DEPTH);
      cnt    <= busy ? cnt + 1'b1 : '0;
      if (busy) begin
        regs[cnt]  <= '0;
        dirty[cnt] <= 1'b0;
      end else if (wr_ok) begin
        regs[waddr]  <= wdata;
        dirty[waddr] <= 1'b1;
      end
    end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port (
      .clk    (clk),
      .rst    (rst),
      .re     (re[i]),
      .raddr  (raddr[i*AW +: AW]),
      .regs   (regs),
`ifdef REGFILE_BYPASS_EN
      .wr_ok  (wr_ok),
      .waddr  (waddr),
      .wdata  (wdata),
`endif
      .rdata  (rdata[i*WIDTH +: WIDTH]),
      .rvalid (rvalid[i])
    );
  end
endmodule
